// File: rtl/packet_copy_arbiter_pkg.sv
// Shared constants and FSM state type for the packet-copy arbiter.
package packet_copy_arbiter_pkg;

  localparam int unsigned NumPorts     = 4;
  localparam int unsigned PortW        = 2;
  localparam int unsigned DefFifoWidth = 11;
  localparam int unsigned DefDepthRam  = 2048;
  localparam int unsigned DefTimeout   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitReq,
    StXfer,
    StDone
  } state_e;

endpackage

// File: rtl/packet_copy_arbiter_rr_select.sv
// Round-robin pick: first set request bit at or after ptr_i, scanning upward modulo 4.
module packet_copy_arbiter_rr_select
  import packet_copy_arbiter_pkg::*;
(
  input  logic [NumPorts-1:0] req_i,
  input  logic [PortW-1:0]    ptr_i,
  output logic [PortW-1:0]    idx_o,
  output logic                valid_o
);

  // Scan from the farthest offset down so the nearest candidate is assigned last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (req_i[ptr_i + PortW'(i)]) begin
        idx_o   = ptr_i + PortW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_copy_arbiter.sv
// Central packet-copy scheduler: round-robin grant, descriptor capture, byte-wise buffer read.
module packet_copy_arbiter
  import packet_copy_arbiter_pkg::*;
#(
  parameter int unsigned pFIFO_WIDTH = DefFifoWidth,
  parameter int unsigned pDEPTH_RAM  = DefDepthRam,
  parameter int unsigned pTIMEOUT    = DefTimeout,
  localparam int unsigned AW         = $clog2(pDEPTH_RAM)
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic [NumPorts-1:0]           i_pending,
  input  logic [NumPorts-1:0]           i_request,
  input  logic [NumPorts*pFIFO_WIDTH-1:0] i_length,
  input  logic [NumPorts*PortW-1:0]     i_dst_port,
  input  logic [NumPorts*AW-1:0]        i_start_adress,
  input  logic                          i_out_busy,
  output logic [NumPorts-1:0]           o_w_permition,
  output logic [PortW-1:0]              o_rd_sel,
  output logic [AW-1:0]                 o_rd_addr,
  output logic                          o_rd_en,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic [PortW-1:0]              o_dst_port,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int unsigned TW = $clog2(pTIMEOUT) + 1;

  state_e                 state_q;
  logic [PortW-1:0]       sel_q, rr_ptr_q;
  logic [TW-1:0]          tmo_cnt_q;
  logic [AW-1:0]          addr_q;
  logic [pFIFO_WIDTH-1:0] remain_q;
  logic                   first_q;

  logic [PortW-1:0]       rr_idx;
  logic                   rr_valid;
  logic [pFIFO_WIDTH-1:0] req_len;
  logic [AW-1:0]          req_addr;
  logic [PortW-1:0]       req_dst;

  packet_copy_arbiter_rr_select u_rr_select (
    .req_i   (i_pending),
    .ptr_i   (rr_ptr_q),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  assign req_len  = i_length[int'(sel_q) * pFIFO_WIDTH +: pFIFO_WIDTH];
  assign req_addr = i_start_adress[int'(sel_q) * AW +: AW];
  assign req_dst  = i_dst_port[int'(sel_q) * PortW +: PortW];

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      tmo_cnt_q     <= '0;
      addr_q        <= '0;
      remain_q      <= '0;
      first_q       <= 1'b0;
      o_w_permition <= '0;
      o_rd_sel      <= '0;
      o_rd_addr     <= '0;
      o_rd_en       <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      o_dst_port    <= '0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      o_w_permition <= '0;
      o_timeout     <= 1'b0;
      o_rd_en       <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rr_valid) begin
            sel_q   <= rr_idx;
            state_q <= StGrant;
            o_busy  <= 1'b1;
          end
        end
        StGrant: begin
          o_w_permition <= NumPorts'(1) << sel_q;
          tmo_cnt_q     <= '0;
          state_q       <= StWaitReq;
        end
        StWaitReq: begin
          // A request on the terminal-count cycle still wins over the timeout.
          if (i_request[sel_q]) begin
            remain_q   <= req_len;
            addr_q     <= req_addr;
            o_dst_port <= req_dst;
            o_rd_sel   <= sel_q;
            first_q    <= 1'b1;
            state_q    <= (req_len == '0) ? StDone : StXfer;
          end else if (tmo_cnt_q == TW'(pTIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            state_q   <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StXfer: begin
          if (!i_out_busy) begin
            o_rd_en   <= 1'b1;
            o_rd_addr <= addr_q;
            o_sop     <= first_q;
            o_eop     <= (remain_q == pFIFO_WIDTH'(1));
            first_q   <= 1'b0;
            addr_q    <= addr_q + 1'b1;
            remain_q  <= remain_q - 1'b1;
            if (remain_q == pFIFO_WIDTH'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          rr_ptr_q <= sel_q + 1'b1;
          state_q  <= StIdle;
          o_busy   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/packet_copy_arbiter.md
# packet_copy_arbiter

Central scheduler for the packet-copy path: arbitrates between the four per-port pre-arbiters, one at a time. It grants read permission to one port, captures that port's packet descriptor (length, destination port, start address), and sequences a byte-by-byte read of the packet out of that port's shared buffer memory. Fairness between ports is round-robin, and a timeout stops an unresponsive port from stalling the switch.

## Interface
- pFIFO_WIDTH, 11, packet length width in bytes (same value as the pre-arbiter length field)
- pDEPTH_RAM, 2048, per-port buffer depth in bytes; power of two; address width AW = $clog2(pDEPTH_RAM)
- pTIMEOUT, 64, cycles to wait for a descriptor after a grant
- iclk  in  1  single clock
- i_rst  in  1  asynchronous, active-high reset
- i_pending  in  4  bit p = port p holds at least one complete packet
- i_request  in  4  per-port one-cycle descriptor-valid pulse
- i_length  in  4*pFIFO_WIDTH  packed lengths; port p at [p*pFIFO_WIDTH +: pFIFO_WIDTH]
- i_dst_port  in  8  packed 2-bit destination port numbers
- i_start_adress  in  4*AW  packed start addresses
- i_out_busy  in  1  downstream stall
- o_w_permition  out  4  one-hot, one-cycle grant pulse
- o_rd_sel  out  2  buffer select (source port)
- o_rd_addr  out  AW  buffer read address
- o_rd_en  out  1  read strobe
- o_sop, o_eop  out  1  first/last byte markers, qualified by o_rd_en
- o_dst_port  out  2  latched destination port
- o_busy  out  1  high in every state other than IDLE
- o_timeout  out  1  one-cycle pulse when a grant is abandoned

## Operation
- FSM states: IDLE, GRANT, WAIT_REQ, XFER, DONE. All outputs are registered.
- IDLE: if i_pending is nonzero, select the first set bit at or after rr_ptr, scanning upward modulo 4. Latch sel and go to GRANT.
- GRANT: o_w_permition[sel]=1 for this cycle only. Clear the timeout counter. Go to WAIT_REQ.
- WAIT_REQ: when i_request[sel]=1, latch the length, dst_port and start address of port sel.
  - If the latched length is 0, go to DONE.
  - Otherwise go to XFER.
- WAIT_REQ: i_request bits of non-selected ports are ignored and not queued.
- WAIT_REQ timeout: the counter increments each cycle. When it reaches pTIMEOUT-1 with no request, pulse o_timeout and go to DONE.
- XFER, cycles with i_out_busy=0:
  - o_rd_en=1 and o_rd_addr=current address.
  - The address increments modulo pDEPTH_RAM (natural wrap, no bounds check).
  - The remaining count decrements.
  - o_sop=1 on the first byte; o_eop=1 when the remaining count is 1. After the eop byte, go to DONE.
- XFER, cycles with i_out_busy=1: o_rd_en=0, and address and count hold.
- DONE: rr_ptr = sel+1 mod 4, applied on completion, zero-length and timeout alike. Go to IDLE.
- Lengths are unsigned, pFIFO_WIDTH bits. The count register is pFIFO_WIDTH bits wide, so the maximum length is 2^pFIFO_WIDTH-1.

## Timing
- Reset (asynchronous, immediate, valid in any state, including mid-XFER):
  - state=IDLE, rr_ptr=0, sel=0.
  - All outputs 0.
  - Latched descriptor and counters cleared.
  - A transfer in progress is dropped with no eop.
- Pending seen in IDLE at cycle n -> o_w_permition high during cycle n+2. The IDLE->GRANT transition takes one cycle and the registered output takes one more.
- Request at cycle m -> first o_rd_en at cycle m+2.
- An unstalled packet of L bytes gives exactly L consecutive o_rd_en cycles.
- Minimum gap between the eop of one packet and the next grant: 3 cycles (DONE, IDLE, GRANT).
- A request in the same cycle as the timeout terminal count is accepted; the request wins.
- i_out_busy asserted on the eop cycle: eop is held until the byte is issued.
- Only one port is granted at a time, and no new grant is issued while o_busy=1.

## Structure
- Shared header: FSM state localparams, port count 4, pFIFO_WIDTH, pDEPTH_RAM.
- Sub-module rr_select: 4-bit request plus 2-bit pointer in, 2-bit index plus valid out; purely combinational.
- Implementation is roughly 200 lines.

## Test plan
- Single packet:
  - Stimulus: i_pending=0001; port 0 request with length 5, start 100, dst 2.
  - Response: one grant pulse on bit 0; o_rd_addr 100..104 with o_rd_en on 5 cycles; sop on 100, eop on 104; o_dst_port=2.
- Round-robin:
  - Stimulus: i_pending=1111 held; every port answers its grant.
  - Response: grant order 0,1,2,3,0; no port granted twice in a row.
- Wrap and stall:
  - Stimulus: length 4, start pDEPTH_RAM-2; i_out_busy high for 3 cycles after the first byte.
  - Response: addresses 2046, 2047, 0, 1; no o_rd_en while busy; eop on address 1.
- Timeout:
  - Stimulus: port 2 granted but never requests; port 3 pending.
  - Response: o_timeout pulse pTIMEOUT cycles after the grant; next grant goes to port 3.
- Zero length and stray request:
  - Stimulus: length 0 on the granted port; i_request[1] pulses while port 0 is granted.
  - Response: no o_rd_en; the stray request is ignored; rr_ptr advances.
- Reset mid-XFER:
  - Stimulus: assert i_rst on byte 3 of a 10-byte packet.
  - Response: all outputs 0 in the same cycle; after release, the next grant goes to port 0.
